// File: rtl/board_pkg.sv
// Shared board definitions: default dimensions and loader FSM state encoding.
// The read-back side imports the same package so both agree on the encoding.
package board_pkg;

  localparam int BOARD_WIDTH_DEF  = 32;
  localparam int BOARD_HEIGHT_DEF = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Row counter width: clog2 of the row count, never narrower than one bit.
  function automatic int cnt_width(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/board_loader.sv
// Board loader: collects BOARD_HEIGHT rows into a shadow register, then
// issues a one-cycle set_state strobe so the board can parallel-load them.
// An abort during the load drops back to IDLE without committing.
module board_loader
  import board_pkg::*;
#(
  parameter int BOARD_WIDTH  = BOARD_WIDTH_DEF,
  parameter int BOARD_HEIGHT = BOARD_HEIGHT_DEF
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic [BOARD_WIDTH-1:0]              row_data,
  input  logic                                row_valid,
  output logic                                row_ready,
  output logic [BOARD_WIDTH*BOARD_HEIGHT-1:0] new_board_state,
  output logic                                set_state,
  output logic                                busy,
  output logic                                done
);

  localparam int BOARD_SIZE = BOARD_WIDTH * BOARD_HEIGHT;
  localparam int CNT_W      = cnt_width(BOARD_HEIGHT);

  logic [1:0]            state_r;
  logic [1:0]            state_s;
  logic [CNT_W-1:0]      row_cnt_r;
  logic [BOARD_SIZE-1:0] shadow_r;
  logic                  row_ready_r;
  logic                  set_state_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  xfer_s;
  logic                  last_row_s;

  // Transfer qualification: abort in the same cycle cancels the row write.
  always_comb begin
    xfer_s     = 1'b0;
    last_row_s = (row_cnt_r == CNT_W'(BOARD_HEIGHT - 1));
    if ((state_r == ST_LOAD) && row_valid && row_ready_r && !abort) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
  end

  // Next-state logic for the IDLE -> LOAD -> COMMIT -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_s = ST_IDLE;
        end else if (xfer_s && last_row_s) begin
          state_s = ST_COMMIT;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_COMMIT: state_s = ST_IDLE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // State, row counter, shadow register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      row_cnt_r   <= '0;
      shadow_r    <= '0;
      row_ready_r <= 1'b0;
      set_state_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      // Outputs are decoded from the next state so they line up with it.
      row_ready_r <= (state_s == ST_LOAD);
      set_state_r <= (state_s == ST_COMMIT);
      busy_r      <= (state_s == ST_LOAD) || (state_s == ST_COMMIT);
      done_r      <= (state_r == ST_COMMIT);
      // Counter clears on a new load; holds on the last row (no wrap).
      if ((state_r == ST_IDLE) && start) begin
        row_cnt_r <= '0;
      end else if (xfer_s && !last_row_s) begin
        row_cnt_r <= row_cnt_r + CNT_W'(1);
      end else begin
        row_cnt_r <= row_cnt_r;
      end
      if (xfer_s) begin
        shadow_r[int'(row_cnt_r) * BOARD_WIDTH +: BOARD_WIDTH] <= row_data;
      end else begin
        shadow_r <= shadow_r;
      end
    end
  end

  assign row_ready       = row_ready_r;
  assign new_board_state = shadow_r;
  assign set_state       = set_state_r;
  assign busy            = busy_r;
  assign done            = done_r;

endmodule

// File: tb/tb_board_loader.sv
// Directed bench for board_loader: a 4x4 instance for the protocol cases
// and a 32x32 instance for the default-size alternating-row pattern.
module tb_board_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // 4x4 instance signals
  logic        start4 = 1'b0;
  logic        abort4 = 1'b0;
  logic [3:0]  row_data4 = 4'd0;
  logic        row_valid4 = 1'b0;
  logic        row_ready4;
  logic [15:0] board4;
  logic        set_state4;
  logic        busy4;
  logic        done4;

  // 32x32 instance signals
  logic          start32 = 1'b0;
  logic          abort32 = 1'b0;
  logic [31:0]   row_data32 = 32'd0;
  logic          row_valid32 = 1'b0;
  logic          row_ready32;
  logic [1023:0] board32;
  logic          set_state32;
  logic          busy32;
  logic          done32;

  int n_tests = 0;
  int n_fail  = 0;
  int sp4     = 0;
  int dn4     = 0;

  board_loader #(.BOARD_WIDTH(4), .BOARD_HEIGHT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .abort(abort4),
    .row_data(row_data4), .row_valid(row_valid4), .row_ready(row_ready4),
    .new_board_state(board4), .set_state(set_state4), .busy(busy4), .done(done4)
  );

  board_loader #(.BOARD_WIDTH(32), .BOARD_HEIGHT(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .abort(abort32),
    .row_data(row_data32), .row_valid(row_valid32), .row_ready(row_ready32),
    .new_board_state(board32), .set_state(set_state32), .busy(busy32), .done(done32)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (set_state4) sp4++;
    if (done4) dn4++;
  endtask

  // Drives a full 4x4 load with the given rows and idle gaps before each row.
  task automatic load4(input logic [3:0] r0, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [3:0] r3,
                       input int g0, input int g1, input int g2, input int g3);
    logic [3:0] rows [4];
    int gaps [4];
    rows[0] = r0; rows[1] = r1; rows[2] = r2; rows[3] = r3;
    gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      row_valid4 = 1'b0;
      for (int g = 0; g < gaps[r]; g++) tick();
      row_valid4 = 1'b1;
      row_data4  = rows[r];
      tick();
    end
    row_valid4 = 1'b0;
    row_data4  = 4'd0;
  endtask

  initial begin
    int t_first;
    int t_second;
    int idx;
    int sp_before;

    // Reset state
    rst = 1'b0;
    tick();
    tick();
    check("rst_row_ready", {63'd0, row_ready4}, 64'd0);
    check("rst_set_state", {63'd0, set_state4}, 64'd0);
    check("rst_busy", {63'd0, busy4}, 64'd0);
    check("rst_done", {63'd0, done4}, 64'd0);
    check("rst_board", {48'd0, board4}, 64'd0);
    rst = 1'b1;
    tick();
    check("idle_row_ready", {63'd0, row_ready4}, 64'd0);

    // Back-to-back load: start cycle 1, rows cycles 2..5, set_state cycle 6
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("b2b_ready_after_start", {63'd0, row_ready4}, 64'd1);
    check("b2b_busy", {63'd0, busy4}, 64'd1);
    for (int r = 0; r < 4; r++) begin
      check("b2b_no_early_set", {63'd0, set_state4}, 64'd0);
      row_valid4 = 1'b1;
      row_data4  = 4'(1 << r);
      tick();
    end
    row_valid4 = 1'b0;
    check("b2b_set_state", {63'd0, set_state4}, 64'd1);
    check("b2b_board", {48'd0, board4}, 64'h8421);
    check("b2b_ready_low", {63'd0, row_ready4}, 64'd0);
    check("b2b_done_not_yet", {63'd0, done4}, 64'd0);
    tick();
    check("b2b_done", {63'd0, done4}, 64'd1);
    check("b2b_set_gone", {63'd0, set_state4}, 64'd0);
    check("b2b_busy_low", {63'd0, busy4}, 64'd0);
    tick();
    check("b2b_done_one_cycle", {63'd0, done4}, 64'd0);

    // Stalled load: 0..3 idle cycles between rows
    sp_before = sp4;
    load4(4'h1, 4'h2, 4'h4, 4'h8, 0, 1, 2, 3);
    check("gap_set_state", {63'd0, set_state4}, 64'd1);
    check("gap_board", {48'd0, board4}, 64'h8421);
    tick();
    tick();
    tick();
    check("gap_single_set", 64'(sp4 - sp_before), 64'd1);

    // Abort after two rows, coinciding with a third row transfer
    sp_before = sp4;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    row_valid4 = 1'b1;
    row_data4 = 4'hF;
    tick();
    row_data4 = 4'hA;
    tick();
    row_data4 = 4'h5;
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    row_valid4 = 1'b0;
    check("abort_idle_ready", {63'd0, row_ready4}, 64'd0);
    check("abort_idle_busy", {63'd0, busy4}, 64'd0);
    check("abort_rows_kept", {48'd0, board4}, 64'h84AF);
    sp_before = sp_before + dn4;
    idx = dn4;
    tick();
    tick();
    check("abort_no_set", 64'(sp4 + idx), 64'(sp_before));
    check("abort_no_done", 64'(dn4), 64'(idx));
    abort4 = 1'b1;
    tick();
    abort4 = 1'b0;
    check("abort_in_idle_ignored", {63'd0, busy4}, 64'd0);

    // Fresh load after abort
    load4(4'hF, 4'h0, 4'h0, 4'hF, 0, 0, 0, 0);
    check("fresh_set_state", {63'd0, set_state4}, 64'd1);
    check("fresh_board", {48'd0, board4}, 64'hF00F);
    tick();
    tick();

    // start held high: back-to-back loads, start ignored while busy
    sp_before = sp4;
    t_first = -1;
    t_second = -1;
    idx = 0;
    start4 = 1'b1;
    for (int t = 0; t < 12; t++) begin
      row_valid4 = row_ready4;
      row_data4  = 4'(1 << idx);
      tick();
      if (row_valid4) idx = (idx + 1) % 4;
      if (set_state4 && t_first < 0) t_first = t;
      else if (set_state4 && t_second < 0) t_second = t;
    end
    start4 = 1'b0;
    row_valid4 = 1'b0;
    check("held_set_count", 64'(sp4 - sp_before), 64'd2);
    check("held_first_set_tick", 64'(t_first), 64'd4);
    check("held_second_set_tick", 64'(t_second), 64'd10);
    check("held_done_last", {63'd0, done4}, 64'd1);
    check("held_board", {48'd0, board4}, 64'h8421);
    tick();

    // Reset during the COMMIT cycle
    load4(4'h3, 4'h3, 4'h3, 4'h3, 0, 0, 0, 0);
    check("rstc_in_commit", {63'd0, set_state4}, 64'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rstc_set_state", {63'd0, set_state4}, 64'd0);
    check("rstc_done", {63'd0, done4}, 64'd0);
    check("rstc_busy", {63'd0, busy4}, 64'd0);
    check("rstc_ready", {63'd0, row_ready4}, 64'd0);
    check("rstc_board", {48'd0, board4}, 64'd0);
    tick();
    check("rstc_no_late_done", {63'd0, done4}, 64'd0);

    // 32x32: alternating full / empty rows
    start32 = 1'b1;
    tick();
    start32 = 1'b0;
    check("b32_ready", {63'd0, row_ready32}, 64'd1);
    for (int r = 0; r < 32; r++) begin
      row_valid32 = 1'b1;
      row_data32  = (r % 2 == 0) ? 32'hFFFF_FFFF : 32'h0000_0000;
      if (r == 31) check("b32_ready_before_last", {63'd0, row_ready32}, 64'd1);
      tick();
    end
    row_valid32 = 1'b0;
    check("b32_ready_after_last", {63'd0, row_ready32}, 64'd0);
    check("b32_set_state", {63'd0, set_state32}, 64'd1);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("b32_slice_%0d", r), {32'd0, board32[r*32 +: 32]},
            (r % 2 == 0) ? 64'hFFFF_FFFF : 64'd0);
    end
    tick();
    check("b32_done", {63'd0, done32}, 64'd1);
    check("b32_ready_stays_low", {63'd0, row_ready32}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_loader.md
BOARD_LOADER -- requirements
Module: board_loader

Interface
REQ-001 The block SHALL have parameter BOARD_WIDTH, default 32, meaning cells per row and row word width.
REQ-002 The block SHALL have parameter BOARD_HEIGHT, default 32, meaning rows per board.
REQ-003 The block SHALL have local parameter BOARD_SIZE = BOARD_WIDTH*BOARD_HEIGHT, meaning total cell count.
REQ-004 The block SHALL have one clock and a synchronous, active-low reset.
REQ-005 clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  the synchronous, active-low reset.
REQ-007 start  input  1  request to begin a board load; sampled in IDLE only.
REQ-008 abort  input  1  cancel an in-progress load; sampled in LOAD only.
REQ-009 row_data  input  BOARD_WIDTH  one board row; bit x is cell (x, row).
REQ-010 row_valid  input  1  row_data is valid.
REQ-011 row_ready  output  1  block accepts a row this cycle.
REQ-012 new_board_state  output  BOARD_SIZE  assembled board; cell (x,y) at bit y*BOARD_WIDTH+x; feeds the board's parallel-load input.
REQ-013 set_state  output  1  one-cycle commit strobe to the board.
REQ-014 busy  output  1  high in LOAD and COMMIT.
REQ-015 done  output  1  one-cycle pulse after a completed commit.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, LOAD, COMMIT.
REQ-017 In IDLE, row_ready SHALL be 0; start=1 SHALL move to LOAD with row counter cleared to 0 on the next cycle.
REQ-018 In LOAD, row_ready SHALL be 1 (registered, no combinational path from row_valid).
REQ-019 A row SHALL transfer only on a cycle where row_valid=1 and row_ready=1; row_data is written to shadow bits [row*BOARD_WIDTH +: BOARD_WIDTH].
REQ-020 Rows SHALL be accepted in order 0..BOARD_HEIGHT-1; the row counter width SHALL be clog2(BOARD_HEIGHT), minimum 1.
REQ-021 The transfer of row BOARD_HEIGHT-1 SHALL move to COMMIT; row_ready SHALL be 0 in the following cycle, with no counter wrap-around.
REQ-022 In COMMIT, set_state SHALL be 1 for exactly one cycle; the FSM then returns to IDLE with done=1 for that one cycle.
REQ-023 new_board_state SHALL be driven directly from the shadow register and SHALL be stable during the set_state cycle.
REQ-024 Load latency SHALL be: start -> first row_ready one cycle later; last transfer -> set_state next cycle -> done next cycle.
REQ-025 Minimum load time SHALL be BOARD_HEIGHT+2 cycles from start to set_state.
REQ-026 abort=1 in LOAD SHALL return to IDLE next cycle with no set_state and no done pulse; rows already written SHALL remain in the shadow register.
REQ-027 If abort and a row transfer coincide, abort SHALL win and the row SHALL NOT be written.
REQ-028 start in LOAD or COMMIT SHALL be ignored, and abort outside LOAD SHALL be ignored.
REQ-029 start asserted in the same cycle that done is high SHALL begin a new load.
REQ-030 Stalls (row_valid=0) of any length in LOAD SHALL hold the counter and shadow unchanged.
REQ-031 The block SHALL never assert generate_state-related behaviour; that control stays with the host.

Reset
REQ-032 rst=0 at a rising clk edge SHALL force IDLE, row counter=0, shadow register=0, row_ready=0, set_state=0, busy=0, done=0.
REQ-033 Reset asserted mid-LOAD or in COMMIT SHALL suppress any pending set_state and done.
REQ-034 Reset SHALL have priority over start, abort and row transfers.

Structure
REQ-035 The state encoding (IDLE=0, LOAD=1, COMMIT=2, 2-bit) and the default board dimensions SHALL live in a shared package/header, board_pkg, also used by the read-back side.
REQ-036 The block SHALL be a single module with no sub-modules; the row counter and FSM SHALL be inline.

Verification
REQ-037 For 4x4, start, then rows 0x1,0x2,0x4,0x8 back-to-back -> set_state on cycle 6 after start, new_board_state=0x8421, done next cycle.
REQ-038 For 4x4, rows with 0-3 idle cycles between row_valid pulses -> same 0x8421 result; set_state exactly once.
REQ-039 For 4x4, abort after 2 rows -> IDLE, no set_state; a fresh load of 0xF,0x0,0x0,0xF -> 0xF00F.
REQ-040 For 4x4, rst=0 in the COMMIT cycle -> set_state=0 that cycle onward; all outputs 0; shadow 0.
REQ-041 For 32x32, rows 0xFFFFFFFF on even rows and 0x0 on odd rows -> each 32-bit slice of new_board_state alternates; row_ready=0 after the 32nd transfer.
REQ-042 For 4x4, start held high continuously -> back-to-back loads, each with one set_state, and start ignored while busy.
